bullet_pool_ctrl: RTL



---
 rtl/shooter_pkg.sv | 13 +
 rtl/bullet_slot.sv | 64 ++++++
 rtl/bullet_pool_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/shooter_pkg.sv
// shooter_pkg: shared slot state encoding and default bullet constants
package shooter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLY   = 2'd1,
        ERASE = 2'd2
    } slot_state_t;

    localparam int DEFAULT_SPAWN_Y = 100;
    localparam int DEFAULT_STEP    = 1;

endpackage

// File: rtl/bullet_slot.sv
// bullet_slot: one bullet slot FSM (IDLE/FLY/ERASE) with its x/y position registers
//   clk, resetn   : clock, async active-low reset
//   i_alloc       : launch this slot (honoured only while IDLE)
//   i_tick        : frame-rate position update pulse
//   i_hit         : collision flag (honoured only while FLY)
//   i_spawn_x     : x loaded at launch
//   o_state       : current slot state
//   o_x, o_y      : held coordinates
//   o_erase       : high for the single ERASE cycle
module bullet_slot
    import shooter_pkg::*;
#(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 7,
    parameter int SPAWN_Y = DEFAULT_SPAWN_Y,
    parameter int STEP    = DEFAULT_STEP
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_alloc,
    input  logic               i_tick,
    input  logic               i_hit,
    input  logic [X_WIDTH-1:0] i_spawn_x,
    output slot_state_t        o_state,
    output logic [X_WIDTH-1:0] o_x,
    output logic [Y_WIDTH-1:0] o_y,
    output logic               o_erase
);

    slot_state_t        r_state;
    logic [X_WIDTH-1:0] r_x;
    logic [Y_WIDTH-1:0] r_y;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_alloc) begin
                    r_state <= FLY;
                    r_x     <= i_spawn_x;
                    r_y     <= Y_WIDTH'(SPAWN_Y);
                end
                // hit has priority over tick; the top check happens before subtracting
                FLY: if (i_hit) begin
                    r_state <= ERASE;
                end else if (i_tick) begin
                    if (int'(r_y) < STEP) r_state <= ERASE;
                    else r_y <= r_y - Y_WIDTH'(STEP);
                end
                ERASE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_state = r_state;
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_erase = (r_state == ERASE);

endmodule

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl: pool of bullet slots with fire edge detect, cooldown and lowest-index allocation
//   clk, resetn   : clock, async active-low reset
//   fire          : fire key level; rising edge requests a launch
//   player_x      : x latched into the launched slot
//   tick          : frame-rate movement / cooldown pulse
//   hit           : per-slot collision flags
//   active        : per-slot FLY indication
//   erase         : per-slot one-cycle erase strobe
//   bullet_x/y    : packed per-slot coordinates
//   fired         : registered launch-accepted pulse, with fired_slot
//   dropped       : registered fire-edge-rejected pulse
//   active_count  : number of slots in FLY
module bullet_pool_ctrl
    import shooter_pkg::*;
#(
    parameter int NUM_BULLETS    = 4,
    parameter int X_WIDTH        = 8,
    parameter int Y_WIDTH        = 7,
    parameter int SPAWN_Y        = DEFAULT_SPAWN_Y,
    parameter int STEP           = DEFAULT_STEP,
    parameter int COOLDOWN_TICKS = 8,
    localparam int FS_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
    localparam int AC_W = $clog2(NUM_BULLETS + 1)
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           fire,
    input  logic [X_WIDTH-1:0]             player_x,
    input  logic                           tick,
    input  logic [NUM_BULLETS-1:0]         hit,
    output logic [NUM_BULLETS-1:0]         active,
    output logic [NUM_BULLETS-1:0]         erase,
    output logic [NUM_BULLETS*X_WIDTH-1:0] bullet_x,
    output logic [NUM_BULLETS*Y_WIDTH-1:0] bullet_y,
    output logic                           fired,
    output logic [FS_W-1:0]                fired_slot,
    output logic                           dropped,
    output logic [AC_W-1:0]                active_count
);

    localparam int CD_W = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    logic                   r_fire_q;
    logic                   r_armed;
    logic [CD_W-1:0]        r_cd;
    logic                   r_fired;
    logic                   r_dropped;
    logic [FS_W-1:0]        r_fired_slot;
    logic [NUM_BULLETS-1:0] w_idle;
    logic [NUM_BULLETS-1:0] w_alloc;
    logic [FS_W-1:0]        w_sel;
    logic                   w_rise;
    logic                   w_accept;
    logic [AC_W-1:0]        w_count;

    // r_armed stays low until fire is seen released after reset, so a key
    // held through reset release never counts as a fresh press
    assign w_rise   = fire & ~r_fire_q & r_armed;
    assign w_accept = w_rise & (|w_idle) & (r_cd == '0);
    assign w_alloc  = w_accept ? (NUM_BULLETS'(1) << w_sel) : '0;

    always_comb begin
        w_sel = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--)
            if (w_idle[i]) w_sel = FS_W'(i);
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_BULLETS; i++)
            w_count = w_count + AC_W'(active[i]);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fire_q     <= 1'b0;
            r_armed      <= 1'b0;
            r_cd         <= '0;
            r_fired      <= 1'b0;
            r_dropped    <= 1'b0;
            r_fired_slot <= '0;
        end else begin
            r_fire_q     <= fire;
            r_armed      <= r_armed | ~fire;
            r_fired      <= w_accept;
            r_dropped    <= w_rise & ~w_accept;
            r_fired_slot <= w_accept ? w_sel : '0;
            // a launch reloads the cooldown even if tick arrives in the same cycle
            if (w_accept) r_cd <= CD_W'(COOLDOWN_TICKS);
            else if (tick && r_cd != '0) r_cd <= r_cd - CD_W'(1);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BULLETS; g++) begin : g_slot
            slot_state_t w_state;
            bullet_slot #(
                .X_WIDTH(X_WIDTH),
                .Y_WIDTH(Y_WIDTH),
                .SPAWN_Y(SPAWN_Y),
                .STEP   (STEP)
            ) u_slot (
                .clk      (clk),
                .resetn   (resetn),
                .i_alloc  (w_alloc[g]),
                .i_tick   (tick),
                .i_hit    (hit[g]),
                .i_spawn_x(player_x),
                .o_state  (w_state),
                .o_x      (bullet_x[g*X_WIDTH +: X_WIDTH]),
                .o_y      (bullet_y[g*Y_WIDTH +: Y_WIDTH]),
                .o_erase  (erase[g])
            );
            assign w_idle[g] = (w_state == IDLE);
            assign active[g] = (w_state == FLY);
        end
    endgenerate

    assign fired        = r_fired;
    assign fired_slot   = r_fired_slot;
    assign dropped      = r_dropped;
    assign active_count = w_count;

endmodule
